// File: rtl/svm_score.sv
// Linear SVM scorer: saturating signed dot product of a HOG feature window with stored weights, plus bias.
// Latency: o_valid pulses 3 cycles after the i_valid of the last feature. Sustains 1 feature/cycle.
// Backpressure: none, so every i_valid is consumed. i_clear aborts the window and discards all in-flight data.
//
// Ports: clk, rst (async, active-low); i_valid/fea/i_clear are the feature stream and abort input;
//        w_addr/w_data form the weight memory read port (1-cycle read latency);
//        score/detect/o_valid carry the window result; busy is high while a window is open or draining.
module svm_score #(
    parameter int FEA_I   = 4,
    parameter int FEA_F   = 8,
    parameter int W_W     = 16,
    parameter int W_F     = 12,
    parameter int WIN_FEA = 3780,
    parameter int ACC_W   = 40,
    parameter logic signed [ACC_W-1:0] BIAS   = '0,
    parameter logic signed [ACC_W-1:0] THRESH = '0,
    localparam int FEA_W  = FEA_I + FEA_F,
    localparam int AW     = $clog2(WIN_FEA)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [FEA_W-1:0]        fea,
    input  logic                    i_clear,
    output logic [AW-1:0]           w_addr,
    input  logic [W_W-1:0]          w_data,
    output logic signed [ACC_W-1:0] score,
    output logic                    detect,
    output logic                    o_valid,
    output logic                    busy
);

    // Product of the zero-extended feature and the signed weight.
    localparam int PROD_W = FEA_W + W_W + 1;
    // The sum is one bit wider than both the accumulator and the product, so the
    // saturation compare sees the true value even when ACC_W < PROD_W.
    localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

    localparam logic signed [SUM_W-1:0] ONE     = 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = (ONE <<< (ACC_W - 1)) - ONE;
    localparam logic signed [SUM_W-1:0] SAT_MIN = -(ONE <<< (ACC_W - 1));

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    // The weight fraction has to fit inside the weight word.
    if (W_F >= W_W) begin : g_bad_wf
        $error("svm_score: W_F must be smaller than W_W");
    end

    logic [AW-1:0]           idx;
    logic [1:0]              state, state_nxt;
    logic                    take, is_last;

    logic                    s1_vld, s1_first, s1_last;
    logic [FEA_W-1:0]        s1_fea;
    logic signed [PROD_W-1:0] fea_e, w_e, prod;

    logic                    s2_vld, s2_first, s2_last;
    logic signed [PROD_W-1:0] s2_prod;

    logic signed [ACC_W-1:0] acc, acc_nxt, score_nxt;
    logic                    emit;

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] x);
        logic signed [ACC_W-1:0] r;
        if (x > SAT_MAX)      r = SAT_MAX[ACC_W-1:0];
        else if (x < SAT_MIN) r = SAT_MIN[ACC_W-1:0];
        else                  r = x[ACC_W-1:0];
        return r;
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_acc(input logic signed [ACC_W-1:0] a);
        return {{(SUM_W-ACC_W){a[ACC_W-1]}}, a};
    endfunction

    function automatic logic signed [SUM_W-1:0] ext_prod(input logic signed [PROD_W-1:0] p);
        return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    // A clear in the same cycle as a feature drops that feature.
    assign take    = i_valid & ~i_clear;
    assign is_last = (idx == AW'(WIN_FEA - 1));
    assign w_addr  = idx;
    assign busy    = (state != IDLE);
    assign emit    = s2_vld & s2_last & ~i_clear;

    // Both operands are extended to the full product width, so the truncated
    // PROD_W-bit result is exact.
    always_comb begin
        fea_e = {{(PROD_W-FEA_W){1'b0}}, s1_fea};
        w_e   = {{(PROD_W-W_W){w_data[W_W-1]}}, w_data};
        prod  = fea_e * w_w_fix(w_e);
    end

    function automatic logic signed [PROD_W-1:0] w_w_fix(input logic signed [PROD_W-1:0] w);
        return w;
    endfunction

    // The score is formed from the accumulator's next value. This lets it land in
    // the same edge as o_valid, which keeps the latency at 3.
    always_comb begin
        acc_nxt   = s2_first ? sat(ext_prod(s2_prod))
                             : sat(ext_acc(acc) + ext_prod(s2_prod));
        score_nxt = sat(ext_acc(acc_nxt) + ext_acc(BIAS));
    end

    always_comb begin
        state_nxt = state;
        if (i_clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_valid) state_nxt = is_last ? DRAIN : ACCUM;
                ACCUM:   if (i_valid && is_last) state_nxt = DRAIN;
                DRAIN: begin
                    // A new window may start while the previous one drains.
                    if (i_valid)                          state_nxt = is_last ? DRAIN : ACCUM;
                    else if (o_valid && !s1_vld && !s2_vld) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx      <= '0;
            state    <= IDLE;
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_fea   <= '0;
            s2_vld   <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
            acc      <= '0;
            score    <= '0;
            detect   <= 1'b0;
            o_valid  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (i_clear)      idx <= '0;
            else if (i_valid) idx <= is_last ? '0 : idx + 1'b1;

            // S0: capture the feature and tag the window boundaries.
            s1_vld <= take;
            if (take) begin
                s1_fea   <= fea;
                s1_first <= (idx == '0);
                s1_last  <= is_last;
            end

            // S1: w_data belongs to the feature held in S1.
            s2_vld <= s1_vld & ~i_clear;
            if (s1_vld) begin
                s2_prod  <= prod;
                s2_first <= s1_first;
                s2_last  <= s1_last;
            end

            // S2: accumulate. On the last feature, also publish the score.
            if (s2_vld && !i_clear) acc <= acc_nxt;
            o_valid <= emit;
            if (emit) begin
                score  <= score_nxt;
                detect <= (score_nxt > THRESH);
            end
        end
    end

endmodule

// File: tb/tb_svm_score.sv
// Randomized scoreboard bench for svm_score with WIN_FEA=4. It drives three configurations:
// 40-bit with zero bias, 40-bit with bias 1.0, and 24-bit to exercise saturation.
// The reference model predicts window scores from features and weights with integer arithmetic.
module tb_svm_score;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [11:0] fea;
    logic        i_clear;

    logic [1:0]         w_addr0, w_addr1, w_addr2;
    logic [15:0]        w_data0, w_data1, w_data2;
    logic signed [39:0] score0, score1;
    logic signed [23:0] score2;
    logic               detect0, detect1, detect2;
    logic               ov0, ov1, ov2;
    logic               busy0, busy1, busy2;

    svm_score #(.WIN_FEA(4)) u0 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .fea(fea), .i_clear(i_clear),
        .w_addr(w_addr0), .w_data(w_data0), .score(score0), .detect(detect0),
        .o_valid(ov0), .busy(busy0));

    svm_score #(.WIN_FEA(4), .BIAS(40'sh0000100000)) u1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .fea(fea), .i_clear(i_clear),
        .w_addr(w_addr1), .w_data(w_data1), .score(score1), .detect(detect1),
        .o_valid(ov1), .busy(busy1));

    svm_score #(.WIN_FEA(4), .ACC_W(24)) u2 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .fea(fea), .i_clear(i_clear),
        .w_addr(w_addr2), .w_data(w_data2), .score(score2), .detect(detect2),
        .o_valid(ov2), .busy(busy2));

    // Weight memories, synchronous read with 1-cycle latency.
    logic signed [15:0] wmem [4];
    always @(posedge clk) begin
        w_data0 <= wmem[w_addr0];
        w_data1 <= wmem[w_addr1];
        w_data2 <= wmem[w_addr2];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        longint sc;
        bit     det;
        int     cyc;
    } exp_t;

    exp_t q0[$], q1[$], q2[$];

    int     ACCW  [3] = '{40, 40, 24};
    longint BIASV [3] = '{0, 64'sd1 <<< 20, 0};
    longint macc  [3];
    int     midx = 0;

    task automatic chk(input string nm, input logic signed [63:0] a, input logic signed [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic longint msat(input longint x, input int w);
        longint mx;
        longint mn;
        mx = (64'sd1 <<< (w - 1)) - 1;
        mn = -(64'sd1 <<< (w - 1));
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
    endfunction

    // Drop predictions whose o_valid edge is at or after lim, because a clear or reset kills them.
    task automatic purge(input int lim);
        while (q0.size() > 0 && q0[$].cyc >= lim) void'(q0.pop_back());
        while (q1.size() > 0 && q1[$].cyc >= lim) void'(q1.pop_back());
        while (q2.size() > 0 && q2[$].cyc >= lim) void'(q2.pop_back());
    endtask

    task automatic model_feature(input int f);
        longint p;
        exp_t   e;
        p = longint'(f) * longint'(wmem[midx]);
        for (int d = 0; d < 3; d++) begin
            macc[d] = (midx == 0) ? msat(p, ACCW[d]) : msat(macc[d] + p, ACCW[d]);
            if (midx == 3) begin
                e.sc  = msat(macc[d] + BIASV[d], ACCW[d]);
                e.det = (e.sc > 0);
                e.cyc = cyc + 3;
                case (d)
                    0: q0.push_back(e);
                    1: q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
        midx = (midx + 1) % 4;
    endtask

    // One cycle of stimulus, driven at the falling edge.
    task automatic step(input bit v, input int f, input bit c);
        @(negedge clk);
        chk("w_addr0", w_addr0, midx);
        chk("w_addr2", w_addr2, midx);
        i_valid = v;
        fea     = f[11:0];
        i_clear = c;
        if (c) begin
            midx = 0;
            purge(cyc + 1);
        end else if (v) begin
            model_feature(f);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0);
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        wmem[0] = a[15:0];
        wmem[1] = b[15:0];
        wmem[2] = c[15:0];
        wmem[3] = d[15:0];
    endtask

    // Monitor: pop and compare whenever a DUT presents a result.
    logic signed [39:0] prev0 = '0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (ov0 === 1'b1) begin
                if (q0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ov0_unexpected actual 1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q0.pop_front();
                    chk("score0", score0, e.sc);
                    chk("detect0", detect0, e.det);
                    chk("latency0", cyc, e.cyc);
                end
            end else if (rst === 1'b1) begin
                chk("score0_hold", score0, prev0);
            end
            prev0 = score0;
            if (ov1 === 1'b1) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ov1_unexpected actual 1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q1.pop_front();
                    chk("score1", score1, e.sc);
                    chk("detect1", detect1, e.det);
                    chk("latency1", cyc, e.cyc);
                end
            end
            if (ov2 === 1'b1) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL ov2_unexpected actual 1 required 0 (cycle %0d)", cyc);
                end else begin
                    e = q2.pop_front();
                    chk("score2", score2, e.sc);
                    chk("detect2", detect2, e.det);
                    chk("latency2", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    int fc [12];

    initial begin
        rst = 1'b0; i_valid = 1'b0; fea = '0; i_clear = 1'b0;
        set_w(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_score", score0, 0);
        chk("rst_detect", detect0, 0);
        chk("rst_ovalid", ov0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_waddr", w_addr0, 0);
        rst = 1'b1;
        idle(2);

        // Unit weights with unit features.
        set_w(16'h1000, 16'h1000, 16'h1000, 16'h1000);
        step(1'b1, 12'h100, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("busy_accum", busy0, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 12'h100, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("busy_drain", busy0, 1);
        idle(5);
        chk("busy_idle", busy0, 0);
        chk("score_unit", score0, 64'sd4 <<< 20);

        // Weights of -1.0. The biased instance should give -3.0.
        set_w(16'hF000, 16'hF000, 16'hF000, 16'hF000);
        for (int i = 0; i < 4; i++) step(1'b1, 12'h100, 1'b0);
        idle(5);
        chk("score_bias", score1, -(64'sd3 <<< 20));
        chk("detect_bias", detect1, 0);

        // Back-to-back windows with mixed random weights.
        set_w($urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 12; i++) begin
            fc[i] = $urandom_range(0, 4095);
            step(1'b1, fc[i], 1'b0);
        end
        idle(5);

        // The same features again, with random gaps between them.
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(0, 3));
            step(1'b1, fc[i], 1'b0);
        end
        idle(5);

        // Saturation of the 24-bit instance, positive then negative.
        set_w(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) step(1'b1, 12'hFFF, 1'b0);
        idle(5);
        chk("sat_pos", score2, 64'sh7FFFFF);
        set_w(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        for (int i = 0; i < 4; i++) step(1'b1, 12'hFFF, 1'b0);
        idle(5);
        chk("sat_neg", score2, -(64'sd1 <<< 23));

        // Abort a window, then abort again with a colliding feature, then run fresh features.
        set_w($urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 2; i++) step(1'b1, $urandom_range(0, 4095), 1'b0);
        step(1'b0, 0, 1'b1);
        step(1'b1, $urandom_range(0, 4095), 1'b0);
        step(1'b1, $urandom_range(0, 4095), 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(0, 4095), 1'b0);
        idle(5);

        // Random traffic with occasional clears.
        set_w($urandom, $urandom, $urandom, $urandom);
        for (int i = 0; i < 300; i++)
            step(($urandom % 4) != 0, $urandom_range(0, 4095), ($urandom % 40) == 0);
        idle(5);

        // Asynchronous reset in the middle of a window.
        step(1'b0, 0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(1, 4095), 1'b0);
        idle(5);
        step(1'b1, $urandom_range(0, 4095), 1'b0);
        step(1'b1, $urandom_range(0, 4095), 1'b0);
        @(negedge clk);
        i_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("arst_score", score0, 0);
        chk("arst_detect", detect0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_waddr", w_addr0, 0);
        chk("arst_ovalid", ov0, 0);
        midx = 0;
        purge(cyc + 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, $urandom_range(0, 4095), 1'b0);
        idle(6);

        chk("q0_left", q0.size(), 0);
        chk("q1_left", q1.size(), 0);
        chk("q2_left", q2.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/svm_score.md
# svm_score

Linear SVM scoring engine that consumes the serial HOG feature stream produced by the normalization stage (`fea`/`o_valid`, one 12-bit feature per valid cycle). It fetches the matching weight from an external synchronous weight memory, forms a saturating signed dot product over one detection window of `WIN_FEA` features, adds a bias, and emits a score and a detect flag once per window. It sits directly downstream of the normalizer and upstream of detection/NMS logic.

## Interface
- `FEA_I`, 4, integer bits of the feature (unsigned)
- `FEA_F`, 8, fractional bits of the feature
- `W_W`, 16, weight width (signed two's complement)
- `W_F`, 12, fractional bits of the weight
- `WIN_FEA`, 3780, features per window (105 blocks x 36)
- `ACC_W`, 40, accumulator/score width (signed, fraction `FEA_F+W_F`)
- `BIAS`, 0, signed `ACC_W` bias at accumulator scale
- `THRESH`, 0, signed `ACC_W` detect threshold
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `i_valid`  in  1  feature strobe
- `fea`  in  `FEA_I+FEA_F`  unsigned feature, valid with `i_valid`
- `i_clear`  in  1  synchronous abort of the current window
- `w_addr`  out  ceil(log2(`WIN_FEA`))  weight memory read address
- `w_data`  in  `W_W`  weight; memory returns data 1 cycle after `w_addr`
- `score`  out  `ACC_W`  signed window score, held until next window
- `detect`  out  1  `score > THRESH` (signed), held with `score`
- `o_valid`  out  1  one-cycle pulse when `score`/`detect` update
- `busy`  out  1  high while a window is partially accumulated or in flight

## Operation
- Feature index counter `idx` (0..`WIN_FEA-1`) increments on each `i_valid`; wraps to 0 after `WIN_FEA-1`. `w_addr` is combinationally `idx`.
- Pipeline: S0 (`i_valid` cycle): capture `fea`, tag `first = (idx==0)`, `last = (idx==WIN_FEA-1)`. S1: product = signed(`{1'b0,fea}`) x `w_data`, registered, width `FEA_I+FEA_F+W_W+1`, sign-extended to `ACC_W`. S2: `acc <= first ? prod : sat(acc + prod)`. S3 (if S2 carried `last`): `score <= sat(acc + BIAS)`, `detect`, `o_valid=1`.
- Saturation: on signed overflow clamp to `2^(ACC_W-1)-1` or `-2^(ACC_W-1)`; applies to accumulate and bias add.
- Control FSM: IDLE (idx==0, pipeline empty) -> ACCUM on `i_valid`; ACCUM -> DRAIN when `last` enters pipeline; DRAIN -> IDLE after `o_valid`, or -> ACCUM if a new `i_valid` arrives during drain (no bubble required). `busy = (state != IDLE)`.
- Back-to-back windows: first feature of window N+1 may arrive the cycle after the last of window N; the `first` tag restarts `acc` without corrupting window N's score.
- `i_clear`: idx <= 0, all in-flight valid/tag bits cleared, `acc` unused until next `first`; no `o_valid` for the aborted window; `score`/`detect` keep previous values. `i_clear` with `i_valid` in the same cycle: clear wins, that feature is dropped.
- No backpressure: every `i_valid` is consumed.

## Timing
- Reset: `score=0`, `detect=0`, `o_valid=0`, `busy=0`, `w_addr=0`, idx=0, pipeline valids 0, FSM IDLE. Reset mid-window discards the window.
- Latency: `o_valid` asserts 3 cycles after the `i_valid` cycle of the last feature.
- Throughput: one feature per cycle sustained; one `o_valid` per `WIN_FEA` features.
- `w_data` is sampled exactly 1 cycle after the matching `i_valid`; it is ignored otherwise.
- `score`/`detect` change only in the `o_valid` cycle.

## Test plan
- `WIN_FEA=4`, fea = 1.0 (0x100) x4, weights 1.0 (0x1000) -> one `o_valid` 3 cycles after 4th feature, `score = 4<<20`, `detect=1`.
- Same with weights -1.0 (0xF000), `BIAS = 1<<20` -> `score = -3<<20`, `detect=0`.
- `WIN_FEA=4`, 12 features back-to-back with mixed weights -> 3 `o_valid` pulses 4 cycles apart, each score matches golden dot product independently.
- Gapped `i_valid` (random idle cycles) -> same scores as gapless; `w_addr` advances only on `i_valid`.
- `ACC_W=24`, fea 0xFFF and weight 0x7FFF x4 -> score clamps to 0x7FFFFF; negative weights clamp to 0x800000.
- `i_clear` after 2 of 4 features, then 4 fresh features -> no pulse for aborted window, next score uses only fresh features; async `rst` low mid-window -> all outputs 0 immediately.
